// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: shares one single-port synchronous text RAM between the
// VGA display fetch (absolute priority), a buffered host write port and a
// clear-screen sequencer that fills every cell with one word.
`timescale 1ns/1ps

module text_ram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int CELLS      = 6000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_addr_err,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELLS - 1);
    localparam logic [CNT_W-1:0]      FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] clear_val_q, clear_val_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  host_ready_q, host_ready_d;
    logic                  disp_valid_q;
    logic                  addr_err_q, addr_err_d;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fill_write;
    logic                  ram_we_c;
    logic [DATA_WIDTH-1:0] ram_wdata_c;

    // Host handshake: ready is a flop, so acceptance never depends on this cycle's pop
    always_comb begin
        accept     = host_valid && host_ready_q;
        push       = accept && (host_addr <= LAST_CELL);
        addr_err_d = accept && (host_addr > LAST_CELL);
    end

    // Per-cycle RAM grant: display read, then clear fill, then FIFO head, else hold address
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_c    = 1'b0;
        ram_wdata_c = '0;
        pop         = 1'b0;
        fill_write  = 1'b0;
        if (reset) begin
            if (disp_req) begin
                ram_addr_d = disp_addr;
            end else if (state_q == CLEAR) begin
                fill_write  = 1'b1;
                ram_we_c    = 1'b1;
                ram_addr_d  = cnt_q;
                ram_wdata_c = clear_val_q;
            end else if ((count_q != '0) && ((state_q == IDLE) || (state_q == DRAIN))) begin
                pop         = 1'b1;
                ram_we_c    = 1'b1;
                ram_addr_d  = fifo_addr_q[rd_ptr_q];
                ram_wdata_c = fifo_data_q[rd_ptr_q];
            end
        end
    end

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Clear sequencer next state: drain pending writes, fill every cell, announce completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_val_d = clear_val_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d     = DRAIN;
                    clear_val_d = clear_value;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (fill_write) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        host_ready_d = (count_d != FIFO_FULL) && (state_d == IDLE);
    end

    // Control state, pointers and output flops; reset abandons any clear in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            clear_val_q  <= '0;
            ram_addr_q   <= '0;
            host_ready_q <= 1'b0;
            disp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_val_q  <= clear_val_d;
            ram_addr_q   <= ram_addr_d;
            host_ready_q <= host_ready_d;
            disp_valid_q <= disp_req;
            addr_err_q   <= addr_err_d;
            count_q      <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset; the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= host_addr;
            fifo_data_q[wr_ptr_q] <= host_data;
        end
    end

    assign disp_valid    = disp_valid_q;
    assign disp_data     = disp_valid_q ? ram_rdata : '0;
    assign host_ready    = host_ready_q;
    assign host_addr_err = addr_err_q;
    assign clear_busy    = (state_q != IDLE);
    assign clear_done    = (state_q == DONE);
    assign ram_addr      = ram_addr_d;
    assign ram_we        = ram_we_c;
    assign ram_wdata     = ram_wdata_c;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Testbench for text_ram_arbiter with a behavioural single-port text RAM.
`timescale 1ns/1ps

module tb_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [12:0] disp_addr;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        host_valid;
    logic        host_ready;
    logic [12:0] host_addr;
    logic [15:0] host_data;
    logic        host_addr_err;
    logic        clear_start;
    logic [15:0] clear_value;
    logic        clear_busy;
    logic        clear_done;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;

    int testsRun = 0;
    int testsFailed = 0;

    text_ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_addr_err(host_addr_err),
        .clear_start  (clear_start),
        .clear_value  (clear_value),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #10 clk = ~clk;

    // Text RAM: unwritten cells read as addr + 0x0700, reads return the pre-write word
    logic [15:0] ramMem [0:8191];
    bit          ramWritten [0:8191];

    function automatic logic [15:0] memAt(input logic [12:0] a);
        return ramWritten[a] ? ramMem[a] : (16'h0700 + {3'b000, a});
    endfunction

    always @(posedge clk) begin
        ram_rdata <= memAt(ram_addr);
        if (ram_we) begin
            ramMem[ram_addr]     <= ram_wdata;
            ramWritten[ram_addr] <= 1'b1;
        end
    end

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t wrLog[$];

    always @(posedge clk) begin
        if (ram_we) wrLog.push_back({ram_addr, ram_wdata});
    end

    typedef struct {
        logic        dispReq;
        logic [12:0] dispAddr;
        logic        hostValid;
        logic [12:0] hostAddr;
        logic [15:0] hostData;
        logic        expReady;
        logic        expWe;
        logic [12:0] expAddr;
        logic [15:0] expWdata;
        logic        expValid;
        logic [15:0] expData;
        logic        expErr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        disp_req   = v.dispReq;
        disp_addr  = v.dispAddr;
        host_valid = v.hostValid;
        host_addr  = v.hostAddr;
        host_data  = v.hostData;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".host_ready"}, 32'(host_ready), 32'd0);
        checkOutput({tag, ".disp_valid"}, 32'(disp_valid), 32'd0);
        checkOutput({tag, ".disp_data"}, 32'(disp_data), 32'd0);
        checkOutput({tag, ".host_addr_err"}, 32'(host_addr_err), 32'd0);
        checkOutput({tag, ".clear_busy"}, 32'(clear_busy), 32'd0);
        checkOutput({tag, ".clear_done"}, 32'(clear_done), 32'd0);
        checkOutput({tag, ".ram_we"}, 32'(ram_we), 32'd0);
        checkOutput({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
        checkOutput({tag, ".ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    // Display reads every 8 cycles: one-cycle latency and no writes
    task automatic displayTest();
        for (int a = 0; a < 100; a++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                disp_req  = (k == 0);
                disp_addr = 13'(a);
                #1;
                checkOutput($sformatf("disp%0d.k%0d.valid", a, k), 32'(disp_valid), 32'(k == 1));
                if (k == 1) checkOutput($sformatf("disp%0d.data", a), 32'(disp_data), 32'(16'h0700 + 16'(a)));
                checkOutput($sformatf("disp%0d.k%0d.we", a, k), 32'(ram_we), 32'd0);
            end
        end
        @(negedge clk);
        disp_req = 1'b0;
    endtask

    // Cycle-by-cycle vectors covering grant order, read-beats-write and illegal address
    task automatic tableTest();
        vec_t vecs[15];
        vecs[0]  = '{1'b1, 13'd5,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'd5,    16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'd5,    16'h0000, 1'b1, 16'h0705, 1'b0};
        vecs[2]  = '{1'b0, 13'd0,    1'b1, 13'h010,  16'hAA41, 1'b1, 1'b0, 13'd5,    16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 13'd0,    1'b1, 13'h011,  16'hAA42, 1'b1, 1'b1, 13'h010,  16'hAA41, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b1, 13'h011,  1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h011,  16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b1, 13'h011,  16'hAA42, 1'b1, 16'h0711, 1'b0};
        vecs[6]  = '{1'b0, 13'd0,    1'b1, 13'd6000, 16'h1234, 1'b1, 1'b0, 13'h011,  16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h011,  16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h011,  16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 13'h010,  1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h010,  16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'h010,  16'h0000, 1'b1, 16'hAA41, 1'b0};
        vecs[11] = '{1'b1, 13'd99,   1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'd99,   16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 13'd0,    1'b1, 13'h012,  16'hAA43, 1'b1, 1'b0, 13'd99,   16'h0000, 1'b1, 16'h0763, 1'b0};
        vecs[13] = '{1'b1, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b0, 13'd0,    16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[14] = '{1'b0, 13'd0,    1'b0, 13'd0,    16'h0000, 1'b1, 1'b1, 13'h012,  16'hAA43, 1'b1, 16'h0700, 1'b0};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d.ready", i), 32'(host_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d.we", i), 32'(ram_we), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d.addr", i), 32'(ram_addr), 32'(vecs[i].expAddr));
            if (vecs[i].expWe) checkOutput($sformatf("vec%0d.wdata", i), 32'(ram_wdata), 32'(vecs[i].expWdata));
            checkOutput($sformatf("vec%0d.valid", i), 32'(disp_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) checkOutput($sformatf("vec%0d.data", i), 32'(disp_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d.err", i), 32'(host_addr_err), 32'(vecs[i].expErr));
        end
        @(negedge clk);
        disp_req   = 1'b0;
        host_valid = 1'b0;
    endtask

    // Back-to-back host writes with a free RAM: each retires the cycle after acceptance
    task automatic plainBurst();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            host_valid = (k < 6);
            host_addr  = 13'(16 + k);
            host_data  = 16'hAA41 + 16'(k);
            #1;
            if (k < 6) checkOutput($sformatf("burst.ready%0d", k), 32'(host_ready), 32'd1);
            checkOutput($sformatf("burst.we%0d", k), 32'(ram_we), 32'(k >= 1 && k <= 6));
            if (k >= 1 && k <= 6) begin
                checkOutput($sformatf("burst.addr%0d", k), 32'(ram_addr), 32'(16 + k - 1));
                checkOutput($sformatf("burst.wdata%0d", k), 32'(ram_wdata), 32'(16'hAA41 + 16'(k - 1)));
            end
        end
        host_valid = 1'b0;
    endtask

    // Display held every cycle: FIFO fills, ready drops after 4, then everything drains in order
    task automatic fullBurst();
        int accepted = 0;
        int weWhileDisp = 0;
        wrLog.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            disp_req   = 1'b1;
            disp_addr  = 13'd200;
            host_valid = (accepted < 6);
            host_addr  = 13'(24 + accepted);
            host_data  = 16'hBB41 + 16'(accepted);
            #1;
            if (ram_we) weWhileDisp++;
            if (host_valid && host_ready) accepted++;
        end
        checkOutput("full.accepted", 32'(accepted), 32'd4);
        checkOutput("full.readyLow", 32'(host_ready), 32'd0);
        checkOutput("full.weWhileDisp", 32'(weWhileDisp), 32'd0);
        for (int k = 0; k < 30 && accepted < 6; k++) begin
            @(negedge clk);
            disp_req   = 1'b0;
            host_valid = 1'b1;
            host_addr  = 13'(24 + accepted);
            host_data  = 16'hBB41 + 16'(accepted);
            #1;
            if (host_ready) accepted++;
        end
        checkOutput("full.allAccepted", 32'(accepted), 32'd6);
        @(negedge clk);
        disp_req   = 1'b0;
        host_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("full.logSize", 32'(wrLog.size()), 32'd6);
        for (int k = 0; k < 6 && k < wrLog.size(); k++) begin
            checkOutput($sformatf("full.order%0d", k), 32'(wrLog[k]), 32'({13'(24 + k), 16'hBB41 + 16'(k)}));
        end
    endtask

    // Host write competing with five consecutive display reads
    task automatic contention();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            disp_req   = (c < 5);
            disp_addr  = 13'(300 + c);
            host_valid = (c == 0);
            host_addr  = 13'h020;
            host_data  = 16'hBEEF;
            #1;
            if (c < 5) checkOutput($sformatf("cont.we%0d", c), 32'(ram_we), 32'd0);
            if (c >= 1) begin
                checkOutput($sformatf("cont.valid%0d", c), 32'(disp_valid), 32'd1);
                checkOutput($sformatf("cont.data%0d", c), 32'(disp_data), 32'(16'h0700 + 16'(300 + c - 1)));
            end
            if (c == 5) begin
                checkOutput("cont.we5", 32'(ram_we), 32'd1);
                checkOutput("cont.addr5", 32'(ram_addr), 32'h20);
                checkOutput("cont.wdata5", 32'(ram_wdata), 32'hBEEF);
            end
        end
        @(negedge clk);
        host_valid = 1'b0;
        disp_req   = 1'b0;
    endtask

    // Full clear with two pending host writes and periodic display reads
    task automatic clearTest();
        int fills = 0, firstFill = -1, lastFill = -1, doneCyc = -1;
        int dispInWindow = 0, addrErrs = 0, otherWrites = 0;
        int weWhileDisp = 0, readyWhileBusy = 0, busyAfter = 0;
        wrLog.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            disp_req    = 1'b1;
            disp_addr   = 13'(400 + c);
            host_valid  = (c < 2);
            host_addr   = 13'(48 + c);
            host_data   = 16'hC001 + 16'(c);
            clear_start = (c == 2);
            clear_value = 16'h0720;
        end
        for (int cyc = 3; cyc < 9000; cyc++) begin
            @(negedge clk);
            host_valid  = 1'b0;
            disp_req    = (cyc % 8 == 0);
            disp_addr   = 13'(500 + (cyc % 64));
            clear_start = (cyc == 1000);
            if (cyc == 1000) clear_value = 16'h1111;
            #1;
            if (cyc == 3) checkOutput("clr.busyAfterStart", 32'(clear_busy), 32'd1);
            if (disp_req && ram_we) weWhileDisp++;
            if (clear_busy && host_ready) readyWhileBusy++;
            if (disp_req && fills > 0 && fills < 6000) dispInWindow++;
            if (ram_we && ram_wdata == 16'h0720) begin
                if (fills == 0) firstFill = cyc;
                if (32'(ram_addr) != fills) addrErrs++;
                fills++;
                lastFill = cyc;
            end else if (ram_we && fills > 0) begin
                otherWrites++;
            end
            if (clear_done) begin
                doneCyc = cyc;
                checkOutput("clr.busyInDone", 32'(clear_busy), 32'd1);
                break;
            end
        end
        checkOutput("clr.doneSeen", 32'(doneCyc >= 0), 32'd1);
        checkOutput("clr.fillCount", 32'(fills), 32'd6000);
        checkOutput("clr.fillAddrErrs", 32'(addrErrs), 32'd0);
        checkOutput("clr.otherWrites", 32'(otherWrites), 32'd0);
        checkOutput("clr.fillCycles", 32'(lastFill - firstFill + 1), 32'(6000 + dispInWindow));
        checkOutput("clr.doneTiming", 32'(doneCyc), 32'(lastFill + 1));
        checkOutput("clr.weWhileDisp", 32'(weWhileDisp), 32'd0);
        checkOutput("clr.readyWhileBusy", 32'(readyWhileBusy), 32'd0);
        checkOutput("clr.logSize", 32'(wrLog.size()), 32'd6002);
        if (wrLog.size() >= 2) begin
            checkOutput("clr.host0", 32'(wrLog[0]), 32'({13'h030, 16'hC001}));
            checkOutput("clr.host1", 32'(wrLog[1]), 32'({13'h031, 16'hC002}));
        end
        @(negedge clk);
        disp_req = 1'b0;
        #1;
        checkOutput("clr.busyDropped", 32'(clear_busy), 32'd0);
        checkOutput("clr.donePulse", 32'(clear_done), 32'd0);
        checkOutput("clr.readyBack", 32'(host_ready), 32'd1);
        repeat (20) begin
            @(negedge clk);
            #1;
            if (clear_busy) busyAfter++;
        end
        checkOutput("clr.secondStartIgnored", 32'(busyAfter), 32'd0);
        checkOutput("clr.mem0", 32'(memAt(13'd0)), 32'h0720);
        checkOutput("clr.mem2500", 32'(memAt(13'd2500)), 32'h0720);
        checkOutput("clr.mem5999", 32'(memAt(13'd5999)), 32'h0720);
    endtask

    // Reset asserted while the fill is writing cell 1234
    task automatic resetMidClear();
        bit found = 1'b0;
        int doneCount = 0;
        @(negedge clk);
        clear_start = 1'b1;
        clear_value = 16'h1F20;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            clear_start = 1'b0;
            #1;
            if (ram_we && ram_addr == 13'd1234) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rst.reachedCell1234", 32'(found), 32'd1);
        #1;
        reset      = 1'b0;
        disp_req   = 1'b1;
        disp_addr  = 13'd77;
        host_valid = 1'b1;
        host_addr  = 13'd5;
        #1;
        checkAllZero("rstMid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        disp_req   = 1'b0;
        host_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst.readyFirstEdge", 32'(host_ready), 32'd1);
        checkOutput("rst.busyCleared", 32'(clear_busy), 32'd0);
        repeat (20) begin
            @(negedge clk);
            #1;
            if (clear_done || clear_busy) doneCount++;
        end
        checkOutput("rst.noClearDone", 32'(doneCount), 32'd0);
        checkOutput("rst.mem0", 32'(memAt(13'd0)), 32'h1F20);
        checkOutput("rst.mem1233", 32'(memAt(13'd1233)), 32'h1F20);
        checkOutput("rst.mem1234", 32'(memAt(13'd1234)), 32'h0720);
    endtask

    initial begin
        reset       = 1'b0;
        disp_req    = 1'b0;
        disp_addr   = '0;
        host_valid  = 1'b0;
        host_addr   = '0;
        host_data   = '0;
        clear_start = 1'b0;
        clear_value = '0;
        #1;
        checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release.ready", 32'(host_ready), 32'd1);
        displayTest();
        tableTest();
        plainBurst();
        fullBurst();
        contention();
        clearTest();
        resetMidClear();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
